// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-cycle multiply/divide unit holding the HI/LO registers
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start, op, a, b    launch MULT(00)/MULTU(01)/DIV(10)/DIVU(11) on rs/rt data, sampled in IDLE
//   hi_we, lo_we, wdata MTHI/MTLO writes, honoured only in IDLE without start
//   busy, done         operation in progress / one-cycle result-written pulse
//   hi, lo             architectural HI/LO registers
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 2;
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t             state;
    logic [CW-1:0]      cnt;
    logic               is_div, neg_q, neg_r, b_zero, rge;
    logic [WIDTH-1:0]   a_raw, opnd, q, rem, abs_a, abs_b;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     msum, rsh;
    // opnd is the multiplicand for multiplies and the divisor for divides
    always_comb begin
        abs_a = (!op[0] && a[WIDTH-1]) ? -a : a;
        abs_b = (!op[0] && b[WIDTH-1]) ? -b : b;
        msum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : '0);
        rsh   = {rem, q[WIDTH-1]};
        rge   = rsh >= {1'b0, opnd};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            a_raw  <= '0;
            opnd   <= '0;
            q      <= '0;
            rem    <= '0;
            prod   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= CALC;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        is_div <= op[1];
                        neg_q  <= !op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r  <= !op[0] && a[WIDTH-1];
                        b_zero <= b == '0;
                        a_raw  <= a;
                        opnd   <= op[1] ? abs_b : abs_a;
                        prod   <= {{WIDTH{1'b0}}, abs_b};
                        q      <= abs_a;
                        rem    <= '0;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= FIX;
                    // the remainder stays below the divisor, so the trial difference fits WIDTH bits
                    if (is_div) begin
                        rem <= rge ? rsh[WIDTH-1:0] - opnd : rsh[WIDTH-1:0];
                        q   <= {q[WIDTH-2:0], rge};
                    end else begin
                        prod <= {msum, prod[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    // first FIX cycle applies signs, second one publishes the result
                    if (cnt == CW'(WIDTH)) begin
                        cnt  <= cnt + 1'b1;
                        prod <= neg_q ? -prod : prod;
                        q    <= b_zero ? '1 : (neg_q ? -q : q);
                        rem  <= b_zero ? a_raw : (neg_r ? -rem : rem);
                    end else begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        hi    <= is_div ? rem : prod[2*WIDTH-1:WIDTH];
                        lo    <= is_div ? q : prod[WIDTH-1:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against a latency/arithmetic model
module tb_muldiv_unit;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
    logic [1:0]  op = '0;
    logic [31:0] a = '0, b = '0, wdata = '0;
    logic        busy, done;
    logic [31:0] hi, lo;
    int          errors = 0, checks = 0;
    bit          chk_en = 1'b0;
    logic        m_busy = 1'b0, m_done = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;
    int          left = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    function automatic void calc(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] h, output logic [31:0] l);
        longint p;
        int xs, ys;
        xs = x;
        ys = y;
        case (o)
            2'd0: begin
                p = longint'(xs) * longint'(ys);
                {h, l} = p;
            end
            2'd1: {h, l} = {32'b0, x} * {32'b0, y};
            2'd2: begin
                if (y == 0) {h, l} = {x, 32'hFFFFFFFF};
                else if (x == 32'h80000000 && y == 32'hFFFFFFFF) {h, l} = {32'h0, 32'h80000000};
                else begin
                    l = xs / ys;
                    h = xs % ys;
                end
            end
            default: begin
                if (y == 0) {h, l} = {x, 32'hFFFFFFFF};
                else begin
                    l = x / y;
                    h = x % y;
                end
            end
        endcase
    endfunction

    // Reference: a result appears 34 edges after an accepted start; writes only when idle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_hi = '0; m_lo = '0; left = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                left--;
                if (left == 0) begin
                    m_busy = 1'b0; m_done = 1'b1; m_hi = r_hi; m_lo = r_lo;
                end
            end else if (start) begin
                calc(op, a, b, r_hi, r_lo);
                m_busy = 1'b1;
                left = 34;
            end else begin
                if (hi_we) m_hi = wdata;
                if (lo_we) m_lo = wdata;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (chk_en) begin
            #1;
            chk("model_busy", busy, m_busy);
            chk("model_done", done, m_done);
            chk("model_hi", hi, m_hi);
            chk("model_lo", lo, m_lo);
        end
    end

    task automatic go(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n, output int bc);
        n = 0;
        bc = busy;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
            bc += busy;
        end
        if (!done) chk("done_timeout", 32'(done), 32'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return $urandom % 16;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bc, seen;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        // MULTU max*max with latency and busy length
        go(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(n, bc);
        chk("multu_latency", n, 34);
        chk("multu_busy_cycles", bc, 34);
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 32'h00000001);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'h0);
        // signed multiply and divide
        go(2'd0, 32'hFFFFFFFD, 32'd7);
        wait_done(n, bc);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFEB);
        go(2'd2, 32'hFFFFFFF9, 32'd2);
        wait_done(n, bc);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);
        // divide by zero and signed overflow
        go(2'd3, 32'd100, 32'd0);
        wait_done(n, bc);
        chk("divu0_lo", lo, 32'hFFFFFFFF);
        chk("divu0_hi", hi, 32'h00000064);
        go(2'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_done(n, bc);
        chk("divovf_lo", lo, 32'h80000000);
        chk("divovf_hi", hi, 32'h0);
        // start and MTHI while busy are ignored
        go(2'd1, 32'd6, 32'd7);
        repeat (9) @(negedge clk);
        start = 1'b1; op = 2'd3; a = 32'd9; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'd5;
        @(negedge clk);
        hi_we = 1'b0;
        wait_done(n, bc);
        chk("ignored_hi", hi, 32'h0);
        chk("ignored_lo", lo, 32'd42);
        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5A5A5;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        chk("mthi", hi, 32'hA5A5A5A5);
        chk("mtlo", lo, 32'hA5A5A5A5);
        chk("mt_no_done", 32'(done), 32'h0);
        // reset mid-operation
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h12345678;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        chk("preload_hi", hi, 32'h12345678);
        go(2'd3, 32'd50, 32'd7);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            seen |= int'(done);
        end
        chk("abort_no_done", seen, 0);
        go(2'd3, 32'd50, 32'd7);
        wait_done(n, bc);
        chk("divu_lo", lo, 32'd7);
        chk("divu_hi", hi, 32'd1);
        // back-to-back start in the done cycle
        go(2'd1, 32'd2, 32'd5);
        wait_done(n, bc);
        chk("b2b_first_lo", lo, 32'd10);
        start = 1'b1; op = 2'd1; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, bc);
        chk("b2b_latency", n, 34);
        chk("b2b_lo", lo, 32'd12);
        chk("b2b_hi", hi, 32'd0);
        // randomized traffic, checked every cycle by the model
        repeat (6000) begin
            @(negedge clk);
            start = ($urandom % 10) == 0;
            op = 2'($urandom);
            a = pick();
            b = pick();
            hi_we = ($urandom % 6) == 0;
            lo_we = ($urandom % 6) == 0;
            wdata = $urandom;
        end
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        repeat (40) @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
